// File: rtl/alu_shift_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_shift_stage
// Brief    : Registered 16-bit shift execute stage (SLL/SRL/SRA/ROR) with a
//            2-entry in-order output buffer and valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module alu_shift_stage #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [15:0]      in_data,
    input  logic [3:0]       in_shamt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;
    localparam logic [1:0] DEPTH  = 2'd2;

    // One guard bit beyond the data catches the last bit shifted out, which
    // gives carry=0 for a zero shift amount without a special case.
    logic [16:0] w_sll;
    logic [16:0] w_srl;
    logic [16:0] w_sra;
    logic [15:0] w_ror;
    logic [4:0]  w_ror_lsh;
    logic [15:0] w_res;
    logic        w_carry;

    // Shift datapath and carry selection
    always_comb begin
        w_sll     = {1'b0, in_data} << in_shamt;
        w_srl     = {in_data, 1'b0} >> in_shamt;
        w_sra     = 17'($signed({in_data, 1'b0}) >>> in_shamt);
        w_ror_lsh = 5'd16 - {1'b0, in_shamt};
        w_ror     = (in_data >> in_shamt) | (in_data << w_ror_lsh);
        w_res     = in_data;
        w_carry   = 1'b0;
        case (in_op)
            OP_SLL: begin w_res = w_sll[15:0];  w_carry = w_sll[16]; end
            OP_SRL: begin w_res = w_srl[16:1];  w_carry = w_srl[0];  end
            OP_SRA: begin w_res = w_sra[16:1];  w_carry = w_sra[0];  end
            OP_ROR: begin
                w_res   = w_ror;
                w_carry = (in_shamt != 4'd0) ? w_ror[15] : 1'b0;
            end
            default: begin w_res = in_data; w_carry = 1'b0; end
        endcase
    end

    // Output buffer storage and control
    logic [15:0]      data_q  [DEPTH];
    logic             zero_q  [DEPTH];
    logic             neg_q   [DEPTH];
    logic             carry_q [DEPTH];
    logic [TAG_W-1:0] tag_q   [DEPTH];
    logic [1:0]       count_q, count_d;
    logic             wr_ptr_q, rd_ptr_q;
    logic             in_ready_q;
    logic             w_push, w_pop;

    assign w_push = in_valid & in_ready_q;
    assign w_pop  = out_valid & out_ready;

    // Occupancy update; simultaneous push and pop leaves it unchanged
    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Buffer entries, pointers, occupancy and registered ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i]  <= '0;
                zero_q[i]  <= 1'b0;
                neg_q[i]   <= 1'b0;
                carry_q[i] <= 1'b0;
                tag_q[i]   <= '0;
            end
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            if (w_push) begin
                data_q[wr_ptr_q]  <= w_res;
                zero_q[wr_ptr_q]  <= (w_res == 16'd0);
                neg_q[wr_ptr_q]   <= w_res[15];
                carry_q[wr_ptr_q] <= w_carry;
                tag_q[wr_ptr_q]   <= in_tag;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q    <= count_d;
            in_ready_q <= (count_d < DEPTH);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = data_q[rd_ptr_q];
    assign out_zero  = zero_q[rd_ptr_q];
    assign out_neg   = neg_q[rd_ptr_q];
    assign out_carry = carry_q[rd_ptr_q];
    assign out_tag   = tag_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_alu_shift_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_shift_stage
// Brief    : Scoreboard bench for alu_shift_stage: driver queues expected
//            results, a negedge monitor pops and compares on every transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_shift_stage;

    typedef struct packed {
        logic [15:0] d;
        logic        z;
        logic        n;
        logic        c;
        logic [3:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'd0;
    logic [15:0] in_data = 16'd0;
    logic [3:0]  in_shamt = 4'd0;
    logic [3:0]  in_tag = 4'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_zero, out_neg, out_carry;
    logic [3:0]  out_tag;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_pop  = 0;
    int   stalls = 0;

    alu_shift_stage #(.TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_data(in_data), .in_shamt(in_shamt), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_zero(out_zero), .out_neg(out_neg), .out_carry(out_carry),
        .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Bit-by-bit reference used for the full-rate stream
    function automatic exp_t ref_shift(input logic [1:0] op, input logic [15:0] x,
                                       input logic [3:0] s, input logic [3:0] tag);
        exp_t e;
        int   k;
        e.d = 16'd0;
        for (int i = 0; i < 16; i++) begin
            k = i + int'(s);
            case (op)
                2'd0: e.d[i] = (i >= int'(s)) ? x[i - int'(s)] : 1'b0;
                2'd1: e.d[i] = (k < 16) ? x[k] : 1'b0;
                2'd2: e.d[i] = (k < 16) ? x[k] : x[15];
                default: e.d[i] = x[k % 16];
            endcase
        end
        if (s == 4'd0)       e.c = 1'b0;
        else if (op == 2'd0) e.c = x[16 - int'(s)];
        else                 e.c = x[int'(s) - 1];
        e.z   = (e.d == 16'd0);
        e.n   = e.d[15];
        e.tag = tag;
        return e;
    endfunction

    // Drive one operation (called at posedge+1), queue its expected result
    task automatic issue(input logic [1:0] op, input logic [15:0] x, input logic [3:0] s,
                         input logic [3:0] tag, input exp_t e);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = x;
        in_shamt = s;
        in_tag   = tag;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        stalls += n;
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout tag=%0d got in_ready=0 exp in_ready=1", tag);
        end else begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted output is compared against the queue head
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            if (sb.size() == 0) begin
                chk("unexpected_output", {16'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk($sformatf("result_tag%0d", e.tag),
                    {9'd0, out_data, out_zero, out_neg, out_carry, out_tag},
                    {9'd0, e});
            end
            n_pop++;
        end
    end

    initial begin
        int p0, s0, n;
        logic [15:0] x;

        // Reset values
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready, 0);
        chk("rst_outputs", {out_data, out_zero, out_neg, out_carry, out_tag}, 0);
        #20 rst_n = 1'b1;                       // t=22, between edges
        #1 chk("ready_before_edge", in_ready, 0);
        cyc(1);
        chk("ready_after_release", in_ready, 1);

        // Directed arithmetic vectors, consumer always ready
        out_ready = 1'b1;
        issue(2'd2, 16'h8000, 4'd15, 4'd1, '{16'hFFFF, 1'b0, 1'b1, 1'b0, 4'd1});
        chk("latency1_out_valid", out_valid, 1);
        issue(2'd1, 16'h8001, 4'd1,  4'd2, '{16'h4000, 1'b0, 1'b0, 1'b1, 4'd2});
        issue(2'd0, 16'h0001, 4'd15, 4'd3, '{16'h8000, 1'b0, 1'b1, 1'b0, 4'd3});
        issue(2'd3, 16'h0001, 4'd1,  4'd4, '{16'h8000, 1'b0, 1'b1, 1'b1, 4'd4});
        issue(2'd0, 16'h0000, 4'd0,  4'd5, '{16'h0000, 1'b1, 1'b0, 1'b0, 4'd5});
        issue(2'd1, 16'h0000, 4'd0,  4'd6, '{16'h0000, 1'b1, 1'b0, 1'b0, 4'd6});
        issue(2'd2, 16'h0000, 4'd0,  4'd7, '{16'h0000, 1'b1, 1'b0, 1'b0, 4'd7});
        issue(2'd3, 16'h0000, 4'd0,  4'd8, '{16'h0000, 1'b1, 1'b0, 1'b0, 4'd8});
        issue(2'd0, 16'h00F0, 4'd4,  4'd9, '{16'h0F00, 1'b0, 1'b0, 1'b0, 4'd9});
        issue(2'd0, 16'hF000, 4'd4,  4'd10, '{16'h0000, 1'b1, 1'b0, 1'b1, 4'd10});
        issue(2'd2, 16'h7FF0, 4'd4,  4'd11, '{16'h07FF, 1'b0, 1'b0, 1'b0, 4'd11});
        issue(2'd2, 16'h8008, 4'd4,  4'd12, '{16'hF800, 1'b0, 1'b1, 1'b1, 4'd12});
        issue(2'd3, 16'h1234, 4'd4,  4'd13, '{16'h4123, 1'b0, 1'b0, 1'b0, 4'd13});
        issue(2'd3, 16'h000F, 4'd3,  4'd14, '{16'hE001, 1'b0, 1'b1, 1'b1, 4'd14});
        issue(2'd3, 16'hA5A5, 4'd0,  4'd15, '{16'hA5A5, 1'b0, 1'b1, 1'b0, 4'd15});
        cyc(3);
        chk("idle_out_valid", out_valid, 0);

        // Backpressure: third push held off until the first pop
        out_ready = 1'b0;
        issue(2'd1, 16'h0100, 4'd8, 4'd1, '{16'h0001, 1'b0, 1'b0, 1'b0, 4'd1});
        issue(2'd0, 16'h0003, 4'd2, 4'd2, '{16'h000C, 1'b0, 1'b0, 1'b0, 4'd2});
        chk("full_in_ready", in_ready, 0);
        chk("full_head_tag", out_tag, 1);
        fork
            issue(2'd2, 16'hFF00, 4'd8, 4'd3, '{16'hFFFF, 1'b0, 1'b1, 1'b0, 4'd3});
            begin
                repeat (2) @(negedge clk);
                chk("held_in_ready", in_ready, 0);
                chk("held_head_tag", out_tag, 1);
                @(posedge clk);
                #1 out_ready = 1'b1;
                @(negedge clk);
                chk("ready_before_pop", in_ready, 0);
                @(posedge clk);
                #1 chk("ready_after_pop", in_ready, 1);
            end
        join
        cyc(4);
        chk("drain_bp", sb.size(), 0);

        // Asynchronous reset with two entries buffered
        out_ready = 1'b0;
        issue(2'd0, 16'h1111, 4'd1, 4'd4, '{16'h2222, 1'b0, 1'b0, 1'b0, 4'd4});
        issue(2'd0, 16'h2222, 4'd1, 4'd5, '{16'h4444, 1'b0, 1'b0, 1'b0, 4'd5});
        chk("pre_rst_out_valid", out_valid, 1);
        #2 rst_n = 1'b0;                         // mid-cycle, no clock edge
        #1;
        sb.delete();
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_outputs", {out_data, out_zero, out_neg, out_carry, out_tag}, 0);
        chk("async_rst_in_ready", in_ready, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("post_rst_ready_pre_edge", in_ready, 0);
        cyc(1);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        // Full-rate stream: push and pop together every cycle
        out_ready = 1'b1;
        p0 = n_pop;
        s0 = stalls;
        for (int k = 0; k < 20; k++) begin
            x = 16'h1357 * 16'(k + 1) ^ 16'hA000;
            issue(2'(k % 4), x, 4'(k % 16), 4'(k),
                  ref_shift(2'(k % 4), x, 4'(k % 16), 4'(k)));
            if (k > 0 && !out_valid) chk("stream_out_valid", out_valid, 1);
        end
        chk("stream_stalls", stalls - s0, 0);
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("stream_pops", n_pop - p0, 20);
        chk("final_drain", sb.size(), 0);
        chk("final_out_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
